vec_mul_seq: RTL and testbench

//  Sequencer for the vec_mul dot-product PE; computes y = K*x (matrix-vector) one row at a time.

---
 rtl/vec_mul_seq_if.sv | 42 ++++
 rtl/vec_mul_seq.sv | 145 ++++++++++++++
 tb/tb_vec_mul_seq.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vec_mul_seq_if.sv
// Signal bundle between the vec_mul sequencer and its environment
// (job control, K-row memory, PE operands/result and the downstream result channel).
interface vec_mul_seq_if #(
    parameter int C        = 8,
    parameter int W_X      = 8,
    parameter int W_K      = 8,
    parameter int MAX_ROWS = 16
);
    localparam int W_R = $clog2(MAX_ROWS) + 1;

    logic               start;
    logic [W_R-1:0]     n_rows;
    logic [C*W_X-1:0]   x_vec;
    logic               busy;
    logic               done;
    logic               row_req;
    logic [W_R-1:0]     row_addr;
    logic               row_valid;
    logic [C*W_K-1:0]   row_data;
    logic               pe_enable;
    logic [C*W_K-1:0]   pe_k;
    logic [C*W_X-1:0]   pe_x;
    logic [W_X-1:0]     pe_y;
    logic               res_valid;
    logic               res_ready;
    logic [W_X-1:0]     res_data;
    logic [W_R-1:0]     res_idx;

    // Sequencer side
    modport slave (
        input  start, n_rows, x_vec, row_valid, row_data, pe_y, res_ready,
        output busy, done, row_req, row_addr, pe_enable, pe_k, pe_x,
               res_valid, res_data, res_idx
    );

    // Environment side: job source, row memory, PE and result sink
    modport master (
        output start, n_rows, x_vec, row_valid, row_data, pe_y, res_ready,
        input  busy, done, row_req, row_addr, pe_enable, pe_k, pe_x,
               res_valid, res_data, res_idx
    );
endinterface

// File: rtl/vec_mul_seq.sv
// Row sequencer for the vec_mul dot-product PE: y = K*x, one row per pass
// (fetch K row, drive PE for PE_LAT+1 cycles, hand result downstream).
module vec_mul_seq #(
    parameter int C        = 8,
    parameter int W_X      = 8,
    parameter int W_K      = 8,
    parameter int MAX_ROWS = 16,
    parameter int PE_LAT   = 1
) (
    input  logic          clk,
    input  logic          rst,
    vec_mul_seq_if.slave  bus
);
    localparam int W_R  = $clog2(MAX_ROWS) + 1;
    localparam int WC_W = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
    localparam logic [WC_W-1:0] WAIT_INIT = WC_W'(PE_LAT - 1);
    localparam logic [W_R-1:0]  ROWS_CAP  = W_R'(MAX_ROWS);
    localparam logic [W_R-1:0]  ONE_R     = W_R'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_OUT
    } state_t;

    state_t             state_q;
    logic [W_R-1:0]     n_rows_q;
    logic [W_R-1:0]     n_rows_d;
    logic [W_R-1:0]     row_idx_q;
    logic [WC_W-1:0]    wait_cnt_q;
    logic [C*W_X-1:0]   x_q;

    logic               busy_q;
    logic               done_q;
    logic               row_req_q;
    logic [W_R-1:0]     row_addr_q;
    logic               pe_enable_q;
    logic [C*W_K-1:0]   pe_k_q;
    logic [C*W_X-1:0]   pe_x_q;
    logic               res_valid_q;
    logic [W_X-1:0]     res_data_q;
    logic [W_R-1:0]     res_idx_q;

    // Oversized jobs are clamped rather than rejected
    always_comb begin
        n_rows_d = bus.n_rows;
        if (bus.n_rows > ROWS_CAP) begin
            n_rows_d = ROWS_CAP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            n_rows_q    <= '0;
            row_idx_q   <= '0;
            wait_cnt_q  <= '0;
            x_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            row_req_q   <= 1'b0;
            row_addr_q  <= '0;
            pe_enable_q <= 1'b0;
            pe_k_q      <= '0;
            pe_x_q      <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_idx_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.n_rows == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            x_q        <= bus.x_vec;
                            n_rows_q   <= n_rows_d;
                            row_idx_q  <= '0;
                            row_addr_q <= '0;
                            row_req_q  <= 1'b1;
                            busy_q     <= 1'b1;
                            state_q    <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    // pe_k_q doubles as the K row register so PE operands only move on ISSUE
                    if (bus.row_valid) begin
                        pe_k_q      <= bus.row_data;
                        pe_x_q      <= x_q;
                        row_req_q   <= 1'b0;
                        pe_enable_q <= 1'b1;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wait_cnt_q <= WAIT_INIT;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt_q == '0) begin
                        res_data_q  <= bus.pe_y;
                        res_idx_q   <= row_idx_q;
                        res_valid_q <= 1'b1;
                        pe_enable_q <= 1'b0;
                        state_q     <= S_OUT;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 1'b1;
                    end
                end
                S_OUT: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        if (row_idx_q == n_rows_q - ONE_R) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            row_idx_q  <= row_idx_q + ONE_R;
                            row_addr_q <= row_idx_q + ONE_R;
                            row_req_q  <= 1'b1;
                            state_q    <= S_FETCH;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.row_req   = row_req_q;
    assign bus.row_addr  = row_addr_q;
    assign bus.pe_enable = pe_enable_q;
    assign bus.pe_k      = pe_k_q;
    assign bus.pe_x      = pe_x_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_idx   = res_idx_q;

endmodule

// File: tb/tb_vec_mul_seq.sv
// Bench for vec_mul_seq: row memory, PE and result sink models around the DUT,
// with a result scoreboard fed from a dot-product reference model.
module tb_vec_mul_seq;
    localparam int C        = 8;
    localparam int W_X      = 8;
    localparam int W_K      = 8;
    localparam int MAX_ROWS = 16;
    localparam int PE_LAT   = 1;
    localparam int W_R      = $clog2(MAX_ROWS) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vec_mul_seq_if #(.C(C), .W_X(W_X), .W_K(W_K), .MAX_ROWS(MAX_ROWS)) bus ();

    vec_mul_seq #(.C(C), .W_X(W_X), .W_K(W_K), .MAX_ROWS(MAX_ROWS), .PE_LAT(PE_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int             idx;
        logic [W_X-1:0] data;
    } exp_t;

    exp_t             exp_q[$];
    int               n_cmp = 0;
    int               n_err = 0;
    int               xs[C];
    int               km[MAX_ROWS][C];
    logic [C*W_X-1:0] cur_x = '0;
    logic [W_X-1:0]   last_data = '0;
    int               ready_pct = 100;
    int               hold_idx = -1;
    int               hold_left = 0;
    int               rv_max = 0;
    int               slow_row = -1;
    int               slow_dly = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: row r of y = K*x with the sum truncated to W_X bits
    function automatic logic [W_X-1:0] ref_row(input int r);
        int s;
        s = 0;
        for (int j = 0; j < C; j++) s += xs[j] * km[r][j];
        return W_X'(s);
    endfunction

    function automatic logic [C*W_X-1:0] pack_x();
        logic [C*W_X-1:0] v;
        for (int j = 0; j < C; j++) v[j*W_X +: W_X] = W_X'(xs[j]);
        return v;
    endfunction

    function automatic logic [C*W_K-1:0] pack_row(input int r);
        logic [C*W_K-1:0] v;
        for (int j = 0; j < C; j++) v[j*W_K +: W_K] = W_K'(km[r][j]);
        return v;
    endfunction

    function automatic logic [W_X-1:0] pe_dot(input logic [C*W_X-1:0] xv, input logic [C*W_K-1:0] kv);
        int s;
        s = 0;
        for (int j = 0; j < C; j++) s += int'($signed(xv[j*W_X +: W_X])) * int'($signed(kv[j*W_K +: W_K]));
        return W_X'(s);
    endfunction

    task automatic fill_rand();
        for (int j = 0; j < C; j++) xs[j] = int'($urandom_range(0, 255)) - 128;
        for (int r = 0; r < MAX_ROWS; r++)
            for (int j = 0; j < C; j++) km[r][j] = int'($urandom_range(0, 255)) - 128;
    endtask

    task automatic fill_const(input int xv, input int kv, input bit k_is_row);
        for (int j = 0; j < C; j++) xs[j] = xv;
        for (int r = 0; r < MAX_ROWS; r++)
            for (int j = 0; j < C; j++) km[r][j] = k_is_row ? r : kv;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      64'(bus.busy), 0);
        check({tag, "_done"},      64'(bus.done), 0);
        check({tag, "_row_req"},   64'(bus.row_req), 0);
        check({tag, "_row_addr"},  64'(bus.row_addr), 0);
        check({tag, "_pe_enable"}, 64'(bus.pe_enable), 0);
        check({tag, "_pe_k"},      64'(bus.pe_k), 0);
        check({tag, "_pe_x"},      64'(bus.pe_x), 0);
        check({tag, "_res_valid"}, 64'(bus.res_valid), 0);
        check({tag, "_res_data"},  64'(bus.res_data), 0);
        check({tag, "_res_idx"},   64'(bus.res_idx), 0);
    endtask

    // Issues one job and waits (bounded) for done; optionally pokes start mid-job
    task automatic run_job(input int nr, input bit poke_busy, output int lat);
        int eff;
        int cyc;
        eff = (nr > MAX_ROWS) ? MAX_ROWS : nr;
        for (int r = 0; r < eff; r++) exp_q.push_back('{idx: r, data: ref_row(r)});
        bus.x_vec  = pack_x();
        cur_x      = bus.x_vec;
        bus.n_rows = W_R'(nr);
        bus.start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        if (nr == 0) begin
            check("zero_done", 64'(bus.done), 1);
            check("zero_busy", 64'(bus.busy), 0);
            check("zero_row_req", 64'(bus.row_req), 0);
            @(negedge clk);
            check("zero_done_pulse", 64'(bus.done), 0);
            check("zero_busy_after", 64'(bus.busy), 0);
            lat = 0;
            return;
        end
        while (!bus.done && cyc < 3000) begin
            if (poke_busy && cyc == 3) begin
                bus.start  = 1'b1;
                bus.n_rows = W_R'(5);
                bus.x_vec  = ~cur_x;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        lat = cyc;
        check("job_done_seen", 64'(bus.done), 1);
        check("job_busy_at_done", 64'(bus.busy), 0);
        check("job_results_left", 64'(exp_q.size()), 0);
        @(negedge clk);
        check("job_done_pulse", 64'(bus.done), 0);
    endtask

    // Row memory: answers each fetch after a chosen delay, junk data while not valid
    initial begin
        int  ctr;
        int  dly;
        bit  active;
        ctr = 0; dly = 0; active = 0;
        bus.row_valid = 1'b0;
        bus.row_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst && bus.row_req) begin
                if (!active) begin
                    active = 1;
                    ctr = 0;
                    dly = (int'(bus.row_addr) == slow_row) ? slow_dly : int'($urandom_range(0, rv_max));
                end
                if (ctr >= dly && int'(bus.row_addr) < MAX_ROWS) begin
                    bus.row_valid = 1'b1;
                    bus.row_data  = pack_row(int'(bus.row_addr));
                end else begin
                    bus.row_valid = 1'b0;
                    bus.row_data  = {$urandom, $urandom};
                end
                ctr++;
            end else begin
                active = 0;
                bus.row_valid = 1'b0;
            end
        end
    end

    // PE: result of operands applied in cycle t is presented in cycle t+PE_LAT
    initial begin
        logic [W_X-1:0] hist [PE_LAT+1];
        for (int i = 0; i <= PE_LAT; i++) hist[i] = '0;
        bus.pe_y = '0;
        forever begin
            @(negedge clk);
            for (int i = PE_LAT; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = bus.pe_enable ? pe_dot(bus.pe_x, bus.pe_k) : '0;
            bus.pe_y = hist[PE_LAT];
        end
    end

    // Result sink
    initial begin
        bus.res_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.res_valid && hold_left > 0 && int'(bus.res_idx) == hold_idx) begin
                bus.res_ready = 1'b0;
                hold_left--;
            end else begin
                bus.res_ready = ($urandom_range(0, 99) < ready_pct);
            end
        end
    end

    // Scoreboard monitor
    initial begin
        bit             stalled;
        logic [W_X-1:0] held_data;
        logic [W_R-1:0] held_idx;
        exp_t           e;
        stalled = 0; held_data = '0; held_idx = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && bus.res_valid) begin
                if (stalled) begin
                    check("res_hold_data", 64'(bus.res_data), 64'(held_data));
                    check("res_hold_idx", 64'(bus.res_idx), 64'(held_idx));
                end
                if (bus.res_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL res_unexpected: idx %0d data %0h, nothing expected", bus.res_idx, bus.res_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("res_idx", 64'(bus.res_idx), 64'(e.idx));
                        check("res_data", 64'(bus.res_data), 64'(e.data));
                        last_data = bus.res_data;
                    end
                    stalled = 0;
                end else begin
                    stalled   = 1;
                    held_data = bus.res_data;
                    held_idx  = bus.res_idx;
                end
            end else begin
                stalled = 0;
            end
        end
    end

    // PE enable must span exactly ISSUE plus PE_LAT wait cycles, with the job's x
    initial begin
        int run;
        run = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                run = 0;
            end else if (bus.pe_enable) begin
                run++;
                if (run == 1) check("pe_x_operand", 64'(bus.pe_x), 64'(cur_x));
            end else begin
                if (run != 0) check("pe_enable_len", 64'(run), 64'(PE_LAT + 1));
                run = 0;
            end
        end
    end

    initial begin
        int lat;
        int w;
        int n;
        bus.start  = 1'b0;
        bus.n_rows = '0;
        bus.x_vec  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // T1: x all 1, row r all r
        fill_const(1, 0, 1);
        run_job(3, 0, lat);
        check("t1_latency", 64'(lat), 12);

        // T2: downstream stalls 5 cycles on row 1
        hold_idx = 1;
        hold_left = 5;
        fork
            run_job(3, 0, lat);
            begin
                w = 0;
                while (!(bus.res_valid && bus.res_idx == W_R'(1)) && w < 200) begin
                    @(negedge clk);
                    w++;
                end
                for (int i = 0; i < 5; i++) begin
                    check("t2_valid", 64'(bus.res_valid), 1);
                    check("t2_data", 64'(bus.res_data), 8);
                    check("t2_row_req", 64'(bus.row_req), 0);
                    check("t2_pe_enable", 64'(bus.pe_enable), 0);
                    @(negedge clk);
                end
            end
        join
        hold_left = 0;
        hold_idx = -1;

        // T3: row memory answers row 2 three cycles late
        slow_row = 2;
        slow_dly = 3;
        fork
            run_job(3, 0, lat);
            begin
                w = 0;
                n = 0;
                while (!(bus.row_req && bus.row_addr == W_R'(2)) && w < 200) begin
                    @(negedge clk);
                    w++;
                end
                while (bus.row_req && n < 20) begin
                    check("t3_row_addr", 64'(bus.row_addr), 2);
                    check("t3_pe_enable", 64'(bus.pe_enable), 0);
                    n++;
                    @(negedge clk);
                end
                check("t3_req_cycles", 64'(n), 4);
            end
        join
        slow_row = -1;

        // T4: empty job
        run_job(0, 0, lat);

        // start while busy must not relatch or queue a job
        fill_rand();
        run_job(2, 1, lat);
        for (int i = 0; i < 3; i++) begin
            check("busy_start_ignored", 64'(bus.busy), 0);
            @(negedge clk);
        end

        // T6: result is the truncated PE sum, not saturated
        fill_const(127, 127, 0);
        run_job(1, 0, lat);
        check("t6_res_data", 64'(last_data), 64'(8'h08));

        // Oversized job clamps to MAX_ROWS
        fill_rand();
        run_job(20, 0, lat);

        // T5: reset during WAIT of row 1
        fill_const(1, 0, 1);
        for (int r = 0; r < 3; r++) exp_q.push_back('{idx: r, data: ref_row(r)});
        bus.x_vec  = pack_x();
        cur_x      = bus.x_vec;
        bus.n_rows = W_R'(3);
        bus.start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        w = 0;
        while (!(bus.row_req && bus.row_addr == W_R'(1)) && w < 200) begin
            @(negedge clk);
            w++;
        end
        while (!bus.pe_enable && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("t5_reached_row1_issue", 64'(w < 200), 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("t5");
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_no_done", 64'(bus.done), 0);
            check("t5_idle", 64'(bus.busy), 0);
        end

        // Randomised jobs with row latency and downstream backpressure
        rv_max = 3;
        ready_pct = 60;
        for (int j = 0; j < 25; j++) begin
            fill_rand();
            run_job(int'($urandom_range(0, 18)), 0, lat);
        end

        check("final_queue_empty", 64'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
